regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of every register.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; index 0 is x0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port A1D  input  5  decode-stage read address, port 1.
REQ-006 SHALL have port A2D  input  5  decode-stage read address, port 2.
REQ-007 SHALL have port RD1D  output  XLEN  read data, port 1.
REQ-008 SHALL have port RD2D  output  XLEN  read data, port 2.
REQ-009 SHALL have port Busy1D  output  1  port 1 register has an outstanding long-latency write.
REQ-010 SHALL have port Busy2D  output  1  port 2 register has an outstanding long-latency write.
REQ-011 SHALL have port IssueValidD  input  1  instruction leaving decode this cycle.
REQ-012 SHALL have port IssueLongD  input  1  issuing instruction is a load (result arrives at writeback).
REQ-013 SHALL have port IssueRdD  input  5  destination of the issuing instruction.
REQ-014 SHALL have port KillE  input  1  instruction in execute is squashed.
REQ-015 SHALL have port KillRdE  input  5  destination of the squashed instruction.
REQ-016 SHALL have port RegWriteW  input  1  writeback write enable.
REQ-017 SHALL have port RdW  input  5  writeback destination.
REQ-018 SHALL have port ResultW  input  XLEN  writeback data from the result-select stage.
REQ-019 SHALL have port PendingCnt  output  6  number of pending bits set.

Function
REQ-020 SHALL write ResultW into register RdW at rising edge when RegWriteW=1 and RdW!=0.
REQ-021 SHALL ignore all writes to x0; RD1D/RD2D SHALL return 0 whenever the address is 0.
REQ-022 SHALL read combinationally; when RegWriteW=1, RdW!=0, and RdW equals A1D/A2D, that port SHALL return ResultW in the same cycle (write-through bypass).
REQ-023 SHALL set pending[IssueRdD] at edge when IssueValidD=1, IssueLongD=1, IssueRdD!=0.
REQ-024 SHALL clear pending[RdW] at edge when RegWriteW=1.
REQ-025 SHALL clear pending[KillRdE] at edge when KillE=1.
REQ-026 Set and clear on the same index in one cycle: set SHALL win.
REQ-027 Busy1D SHALL equal pending[A1D] AND NOT (RegWriteW AND RdW==A1D); likewise Busy2D; always 0 for address 0.
REQ-028 PendingCnt SHALL be a registered count tracking pending bits exactly: +1 on a new set of a clear bit, -1 per cleared bit; multiple clears of the same bit count once; range 0..31, never wraps.
REQ-029 pending[0] SHALL remain 0 permanently.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all registers, all pending bits, and PendingCnt to 0.
REQ-031 During reset, RD1D/RD2D=0, Busy1D/Busy2D=0, PendingCnt=0; writes and issues are ignored.
REQ-032 Reset asserted mid-operation SHALL drop all outstanding pending state; nothing is retained.

Structure
REQ-033 XLEN, NREG, and reg_addr_t (5-bit) SHALL live in the shared core package.
REQ-034 The pending-bit array and PendingCnt SHALL be one sub-module, regfile_scoreboard; the storage array and bypass stay in regfile_sb.

Verification
REQ-035 Write x5=0x1234 and read A1D=5 on the next cycle -> RD1D=0x1234; same-cycle read returns 0x1234 via bypass.
REQ-036 Write x0=0xFFFF -> RD1D with A1D=0 stays 0; PendingCnt unchanged.
REQ-037 Issue load rd=7, then hold A2D=7 -> Busy2D=1 and PendingCnt=1; writeback rd=7 -> Busy2D=0 that cycle and PendingCnt=0 next cycle.
REQ-038 Same cycle: issue load rd=9 and writeback rd=9 -> pending[9]=1 afterwards, PendingCnt=1.
REQ-039 Issue loads rd=3,4, KillE rd=4 -> PendingCnt=1, Busy for x4=0; kill and writeback both on rd=3 in one cycle -> PendingCnt=0.
REQ-040 Pulse rst_n low asynchronously with 5 pending bits and x1=0xAA -> PendingCnt=0, RD1D(x1)=0 immediately.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Shared core definitions for the register file and its load scoreboard.
// Holds the datapath width, architectural register count, the 5-bit
// register address type and the width of the pending-bit counter.
package regfile_sb_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  // Wide enough for 0..31 outstanding loads (x0 can never be pending).
  localparam int CNT_W  = 6;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : regfile_sb_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Tracks which architectural registers have an outstanding long-latency
// (load) write, and keeps a registered count of those pending bits.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   set_en_i, set_rd_i  - load issuing this cycle and its destination
//   clr_wb_en_i/_rd_i   - writeback retiring a destination
//   clr_kill_en_i/_rd_i - squashed instruction releasing a destination
//   pending_o           - one pending bit per register (bit 0 always 0)
//   pending_cnt_o       - number of pending bits currently set
module regfile_scoreboard
  import regfile_sb_pkg::reg_addr_t, regfile_sb_pkg::CNT_W;
#(
  parameter int NREG = regfile_sb_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en_i,
  input  reg_addr_t        set_rd_i,
  input  logic             clr_wb_en_i,
  input  reg_addr_t        clr_wb_rd_i,
  input  logic             clr_kill_en_i,
  input  reg_addr_t        clr_kill_rd_i,
  output logic [NREG-1:0]  pending_o,
  output logic [CNT_W-1:0] pending_cnt_o
);

  logic [NREG-1:0]  pending_q;
  logic [NREG-1:0]  pending_d;
  logic [NREG-1:0]  set_mask_s;
  logic [NREG-1:0]  clr_mask_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // One-hot decode of a register address.
  function automatic logic [NREG-1:0] dec_onehot(input reg_addr_t a);
    logic [NREG-1:0] m;
    m    = {NREG{1'b0}};
    m[a] = 1'b1;
    return m;
  endfunction

  // Next pending state: clears applied first so a same-index set wins;
  // two clears of one bit collapse naturally in the mask. The count is the
  // population of the next state, so it can never drift from the bits.
  always_comb begin
    set_mask_s = (set_en_i && (set_rd_i != 5'd0)) ? dec_onehot(set_rd_i)
                                                   : {NREG{1'b0}};
    clr_mask_s = (clr_wb_en_i   ? dec_onehot(clr_wb_rd_i)   : {NREG{1'b0}})
               | (clr_kill_en_i ? dec_onehot(clr_kill_rd_i) : {NREG{1'b0}});
    pending_d  = ((pending_q & ~clr_mask_s) | set_mask_s)
               & {{(NREG-1){1'b1}}, 1'b0};
    cnt_d      = {CNT_W{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, pending_d[i]};
    end
  end

  // Pending bits and their count; reset drops everything outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= {NREG{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o     = pending_q;
  assign pending_cnt_o = cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb
// Two-read / one-write integer register file with write-through bypass
// and a load scoreboard that flags registers awaiting a writeback.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   A1D, A2D                   - decode read addresses
//   RD1D, RD2D                 - read data (combinational, x0 reads 0)
//   Busy1D, Busy2D             - read register still awaits a load result
//   IssueValidD/IssueLongD/IssueRdD - issuing instruction, load flag, dest
//   KillE, KillRdE             - squashed execute instruction and its dest
//   RegWriteW, RdW, ResultW    - writeback port
//   PendingCnt                 - registered count of outstanding loads
module regfile_sb
  import regfile_sb_pkg::reg_addr_t, regfile_sb_pkg::CNT_W;
#(
  parameter int XLEN = regfile_sb_pkg::XLEN,
  parameter int NREG = regfile_sb_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_addr_t        A1D,
  input  reg_addr_t        A2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic             Busy1D,
  output logic             Busy2D,
  input  logic             IssueValidD,
  input  logic             IssueLongD,
  input  reg_addr_t        IssueRdD,
  input  logic             KillE,
  input  reg_addr_t        KillRdE,
  input  logic             RegWriteW,
  input  reg_addr_t        RdW,
  input  logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] PendingCnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pending_s;
  logic            wr_en_s;

  // A write is real only outside reset and never to x0; this also gates
  // the bypass so reads stay 0 while reset is held.
  always_comb begin
    wr_en_s = RegWriteW & rst_n & (RdW != 5'd0);
  end

  // Storage next state.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s) begin
      regs_d[RdW] = ResultW;
    end else begin
      regs_d = regs_q;
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: x0 is hard zero, a same-cycle writeback forwards ResultW.
  always_comb begin
    RD1D = regs_q[A1D];
    if (A1D == 5'd0) begin
      RD1D = {XLEN{1'b0}};
    end else if (wr_en_s && (RdW == A1D)) begin
      RD1D = ResultW;
    end else begin
      RD1D = regs_q[A1D];
    end
    RD2D = regs_q[A2D];
    if (A2D == 5'd0) begin
      RD2D = {XLEN{1'b0}};
    end else if (wr_en_s && (RdW == A2D)) begin
      RD2D = ResultW;
    end else begin
      RD2D = regs_q[A2D];
    end
  end

  // Busy drops in the writeback cycle itself, since the bypass already
  // delivers the load result to the reader.
  always_comb begin
    Busy1D = (A1D != 5'd0) & pending_s[A1D] & ~(RegWriteW & (RdW == A1D));
    Busy2D = (A2D != 5'd0) & pending_s[A2D] & ~(RegWriteW & (RdW == A2D));
  end

  regfile_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en_i      (IssueValidD & IssueLongD),
    .set_rd_i      (IssueRdD),
    .clr_wb_en_i   (RegWriteW),
    .clr_wb_rd_i   (RdW),
    .clr_kill_en_i (KillE),
    .clr_kill_rd_i (KillRdE),
    .pending_o     (pending_s),
    .pending_cnt_o (PendingCnt)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model
// (plain register array plus a set of pending destinations).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  A1D, A2D, IssueRdD, KillRdE, RdW;
  logic [63:0] RD1D, RD2D, ResultW;
  logic        Busy1D, Busy2D, IssueValidD, IssueLongD, KillE, RegWriteW;
  logic [5:0]  PendingCnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_regs [32];
  bit   [31:0] m_pend;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
    .Busy1D(Busy1D), .Busy2D(Busy2D), .IssueValidD(IssueValidD),
    .IssueLongD(IssueLongD), .IssueRdD(IssueRdD), .KillE(KillE),
    .KillRdE(KillRdE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .PendingCnt(PendingCnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 64'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return m_regs[a];
  endfunction

  function automatic logic [63:0] exp_busy(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 64'd0;
    if (RegWriteW && RdW == a) return 64'd0;
    return {63'd0, m_pend[a]};
  endfunction

  function automatic logic [63:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return 64'(n);
  endfunction

  task automatic model_clear();
    m_pend = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
  endtask

  task automatic model_step();
    if (RegWriteW) m_pend[RdW] = 1'b0;
    if (KillE) m_pend[KillRdE] = 1'b0;
    if (IssueValidD && IssueLongD && IssueRdD != 5'd0) m_pend[IssueRdD] = 1'b1;
    m_pend[0] = 1'b0;
    if (RegWriteW && RdW != 5'd0) m_regs[RdW] = ResultW;
  endtask

  // ---- every-cycle compare ----
  always @(negedge clk) begin
    check("cmp_rd1",  RD1D, exp_rd(A1D));
    check("cmp_rd2",  RD2D, exp_rd(A2D));
    check("cmp_busy1", {63'd0, Busy1D}, exp_busy(A1D));
    check("cmp_busy2", {63'd0, Busy2D}, exp_busy(A2D));
    check("cmp_cnt",  {58'd0, PendingCnt}, exp_cnt());
  end

  task automatic idle();
    A1D = 5'd0; A2D = 5'd0; IssueValidD = 1'b0; IssueLongD = 1'b0;
    IssueRdD = 5'd0; KillE = 1'b0; KillRdE = 5'd0; RegWriteW = 1'b0;
    RdW = 5'd0; ResultW = 64'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    idle(); IssueValidD = 1'b1; IssueLongD = 1'b1; IssueRdD = rd;
    tick();
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_clear();
    #1 rst_n = 1'b0;
    // writes and reads during reset
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 64'h55; A1D = 5'd1;
    IssueValidD = 1'b1; IssueLongD = 1'b1; IssueRdD = 5'd2;
    #1;
    check("rst_rd1", RD1D, 64'd0);
    check("rst_cnt", {58'd0, PendingCnt}, 64'd0);
    tick(); tick();
    check("rst_cnt_hold", {58'd0, PendingCnt}, 64'd0);
    check("rst_rd1_hold", RD1D, 64'd0);
    idle();
    rst_n = 1'b1;

    // write x5, bypass then registered read
    tick();
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 64'h1234; A1D = 5'd5;
    #1 check("bypass_x5", RD1D, 64'h1234);
    tick(); idle(); A1D = 5'd5;
    #1 check("read_x5", RD1D, 64'h1234);

    // x0 is immutable
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 64'hFFFF; A1D = 5'd0;
    #1 check("x0_bypass", RD1D, 64'd0);
    tick(); idle();
    #1 check("x0_read", RD1D, 64'd0);
    check("x0_cnt", {58'd0, PendingCnt}, 64'd0);

    // load to x7, busy until writeback
    issue_load(5'd7);
    idle(); A2D = 5'd7;
    #1 check("busy_x7", {63'd0, Busy2D}, 64'd1);
    check("cnt_x7", {58'd0, PendingCnt}, 64'd1);
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 64'h77;
    #1 check("busy_x7_wb", {63'd0, Busy2D}, 64'd0);
    check("rd_x7_wb", RD2D, 64'h77);
    tick(); idle(); A2D = 5'd7;
    #1 check("cnt_x7_done", {58'd0, PendingCnt}, 64'd0);

    // set beats clear on same index
    idle(); IssueValidD = 1'b1; IssueLongD = 1'b1; IssueRdD = 5'd9;
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 64'h99;
    tick(); idle(); A1D = 5'd9;
    #1 check("set_wins_cnt", {58'd0, PendingCnt}, 64'd1);
    check("set_wins_busy", {63'd0, Busy1D}, 64'd1);
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 64'h9A;
    tick(); idle();

    // kill releases a destination; double clear counts once
    issue_load(5'd3);
    issue_load(5'd4);
    idle(); KillE = 1'b1; KillRdE = 5'd4;
    tick(); idle(); A1D = 5'd3; A2D = 5'd4;
    #1 check("kill_cnt", {58'd0, PendingCnt}, 64'd1);
    check("kill_busy4", {63'd0, Busy2D}, 64'd0);
    check("kill_busy3", {63'd0, Busy1D}, 64'd1);
    KillE = 1'b1; KillRdE = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 64'h33;
    tick(); idle();
    #1 check("dbl_clr_cnt", {58'd0, PendingCnt}, 64'd0);

    // asynchronous reset with outstanding state
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 64'hAA;
    tick();
    for (int r = 1; r <= 5; r++) issue_load(5'(r));
    idle(); A1D = 5'd1;
    #1 check("pre_rst_rd", RD1D, 64'hAA);
    check("pre_rst_cnt", {58'd0, PendingCnt}, 64'd5);
    rst_n = 1'b0; model_clear();
    #1 check("async_rst_cnt", {58'd0, PendingCnt}, 64'd0);
    check("async_rst_rd", RD1D, 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", {58'd0, PendingCnt}, 64'd0);
    check("post_rst_rd", RD1D, 64'd0);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      IssueValidD = ($urandom_range(0, 1) == 1);
      IssueLongD  = ($urandom_range(0, 2) != 0);
      IssueRdD    = pick_addr();
      KillE       = ($urandom_range(0, 3) == 0);
      KillRdE     = pick_addr();
      RegWriteW   = ($urandom_range(0, 2) == 0);
      RdW         = pick_addr();
      ResultW     = {$urandom, $urandom};
      A1D         = ($urandom_range(0, 3) == 0) ? RdW : pick_addr();
      A2D         = ($urandom_range(0, 3) == 0) ? IssueRdD : pick_addr();
      if (i == 1500) begin
        #1 rst_n = 1'b0; model_clear();
        #1 check("rand_rst_cnt", {58'd0, PendingCnt}, 64'd0);
        rst_n = 1'b1;
      end
      tick();
    end

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_sb
